// File: rtl/i2c_request_arbiter_pkg.sv
// Shared definitions for the I2C request arbiter slice.
//   - FSM state encoding for the arbiter controller
//   - I2C address/data field widths
//   - read/write encoding of the RW command bit
package i2c_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_DONE,
        ST_REPORT,
        ST_GAP
    } state_t;

endpackage

// File: rtl/i2c_request_arbiter_rr_arbiter2.sv
// Two-way round-robin picker.
//   clock, Reset : system clock, asynchronous active-low reset
//   req          : request vector, one bit per requester
//   update       : pulse to record the requester that was just served
//   served_idx   : index (0/1) of the requester that was just served
//   pick         : one-hot winner (combinational), 0 when nothing requested
module rr_arbiter2 (
    input  logic       clock,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served_idx,
    output logic [1:0] pick
);

    // Index of the requester served most recently; resetting it to 1 makes
    // requester 0 win the first tie.
    logic last;

    always_comb begin
        pick = 2'b00;
        if (req == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end else begin
            pick = req;
        end
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            last <= 1'b1;
        end else if (update) begin
            last <= served_idx;
        end
    end

endmodule

// File: rtl/i2c_request_arbiter.sv
// Shares one I2C master bit engine between two requesters.
//   clock, Reset         : system clock, asynchronous active-low reset
//   Req/ReqAddr/ReqRW/ReqData : per-requester one-byte command
//   Grant                : one-hot current owner, 0 when idle
//   Done/AckErr/TimedOut/RdData : completion report to the owner
//   EngGo/EngAddr/EngRW/EngData : launch pulse and command to the engine
//   EngBusy/EngDone/EngNack/EngRdData : engine status and result
module i2c_request_arbiter
    import i2c_pkg::*;
#(
    parameter int TimeoutCycles = 4096,
    parameter int GapCycles     = 3
) (
    input  logic                  clock,
    input  logic                  Reset,
    input  logic [1:0]            Req,
    input  logic [2*ADDR_W-1:0]   ReqAddr,
    input  logic [1:0]            ReqRW,
    input  logic [2*DATA_W-1:0]   ReqData,
    output logic [1:0]            Grant,
    output logic [1:0]            Done,
    output logic                  AckErr,
    output logic                  TimedOut,
    output logic [DATA_W-1:0]     RdData,
    output logic                  EngGo,
    output logic [ADDR_W-1:0]     EngAddr,
    output logic                  EngRW,
    output logic [DATA_W-1:0]     EngData,
    input  logic                  EngBusy,
    input  logic                  EngDone,
    input  logic                  EngNack,
    input  logic [DATA_W-1:0]     EngRdData
);

    localparam int TW = $clog2(TimeoutCycles + 1);
    localparam int GW = $clog2(GapCycles + 1);

    state_t        state, state_nxt;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gcnt;
    logic [1:0]    pick;
    logic          timeout;

    rr_arbiter2 u_rr (
        .clock      (clock),
        .Reset      (Reset),
        .req        (Req),
        .update     (state == ST_REPORT),
        .served_idx (Grant[1]),
        .pick       (pick)
    );

    assign timeout = (tcnt == TW'(TimeoutCycles));

    // Done is decoded from the REPORT state so it is exactly one cycle long
    // and goes low the instant reset is asserted.
    assign Done = (state == ST_REPORT) ? Grant : 2'b00;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if ((|Req) && !EngBusy) state_nxt = ST_LAUNCH;
            ST_LAUNCH:    state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (EngDone || timeout) state_nxt = ST_REPORT;
            ST_REPORT:    state_nxt = ST_GAP;
            ST_GAP:       if (gcnt == '0) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            tcnt     <= '0;
            gcnt     <= '0;
            Grant    <= 2'b00;
            AckErr   <= 1'b0;
            TimedOut <= 1'b0;
            RdData   <= '0;
            EngGo    <= 1'b0;
            EngAddr  <= '0;
            EngRW    <= RW_WRITE;
            EngData  <= '0;
        end else begin
            state <= state_nxt;
            EngGo <= (state == ST_LAUNCH);
            case (state)
                ST_IDLE: begin
                    if (state_nxt == ST_LAUNCH) begin
                        Grant   <= pick;
                        EngAddr <= pick[1] ? ReqAddr[2*ADDR_W-1:ADDR_W] : ReqAddr[ADDR_W-1:0];
                        EngRW   <= ReqRW[pick[1]];
                        EngData <= pick[1] ? ReqData[2*DATA_W-1:DATA_W] : ReqData[DATA_W-1:0];
                    end
                end
                ST_LAUNCH: begin
                    tcnt <= '0;
                end
                ST_WAIT_DONE: begin
                    // A real completion wins over a coincident timeout.
                    if (EngDone) begin
                        AckErr   <= EngNack;
                        TimedOut <= 1'b0;
                        if (EngRW == RW_READ) RdData <= EngRdData;
                    end else if (timeout) begin
                        AckErr   <= 1'b1;
                        TimedOut <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ST_REPORT: begin
                    Grant <= 2'b00;
                    gcnt  <= GW'(GapCycles - 1);
                end
                ST_GAP: begin
                    if (gcnt != '0) gcnt <= gcnt - GW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_request_arbiter.sv
module tb_i2c_request_arbiter;

    localparam int GAP = 3;

    logic        clock = 1'b0;
    logic        Reset;
    logic [1:0]  Req;
    logic [13:0] ReqAddr;
    logic [1:0]  ReqRW;
    logic [15:0] ReqData;
    logic        EngBusy, EngDone, EngNack;
    logic [7:0]  EngRdData;

    logic [1:0]  Grant, Done;
    logic        AckErr, TimedOut, EngGo, EngRW;
    logic [7:0]  RdData, EngData;
    logic [6:0]  EngAddr;

    logic [1:0]  t_Grant, t_Done;
    logic        t_AckErr, t_TimedOut, t_EngGo, t_EngRW;
    logic [7:0]  t_RdData, t_EngData;
    logic [6:0]  t_EngAddr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    i2c_request_arbiter #(.TimeoutCycles(4096), .GapCycles(GAP)) dut (
        .clock(clock), .Reset(Reset), .Req(Req), .ReqAddr(ReqAddr), .ReqRW(ReqRW),
        .ReqData(ReqData), .Grant(Grant), .Done(Done), .AckErr(AckErr),
        .TimedOut(TimedOut), .RdData(RdData), .EngGo(EngGo), .EngAddr(EngAddr),
        .EngRW(EngRW), .EngData(EngData), .EngBusy(EngBusy), .EngDone(EngDone),
        .EngNack(EngNack), .EngRdData(EngRdData)
    );

    i2c_request_arbiter #(.TimeoutCycles(20), .GapCycles(GAP)) dut_t (
        .clock(clock), .Reset(Reset), .Req(Req), .ReqAddr(ReqAddr), .ReqRW(ReqRW),
        .ReqData(ReqData), .Grant(t_Grant), .Done(t_Done), .AckErr(t_AckErr),
        .TimedOut(t_TimedOut), .RdData(t_RdData), .EngGo(t_EngGo), .EngAddr(t_EngAddr),
        .EngRW(t_EngRW), .EngData(t_EngData), .EngBusy(EngBusy), .EngDone(EngDone),
        .EngNack(EngNack), .EngRdData(EngRdData)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Waits (bounded) for a launch pulse on the main (t=0) or timeout (t=1)
    // instance; flags any Done seen while waiting.
    task automatic wait_go(input bit t, input int maxc, output int at, output bit stale);
        at = -1;
        stale = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clock);
            if ((t ? t_Done : Done) !== 2'b00) stale = 1'b1;
            if ((t ? t_EngGo : EngGo) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk(t ? "t_go_bound" : "go_bound", 16'(0), 16'(1));
    endtask

    // Engine model: busy for lat cycles, then a one-cycle EngDone.
    // Returns at the negedge where Done should be visible.
    task automatic finish_txn(input logic nack, input logic [7:0] rd, input int lat, output int at);
        EngBusy = 1'b1;
        tick(lat);
        EngDone = 1'b1;
        EngNack = nack;
        EngRdData = rd;
        at = cyc;
        tick(1);
        EngDone = 1'b0;
        EngNack = 1'b0;
        EngBusy = 1'b0;
    endtask

    initial begin
        int g, g2, d, d0;
        bit stale;
        logic [1:0] seen, expg;

        Reset = 1'b0; Req = 2'b00; ReqAddr = '0; ReqRW = 2'b00; ReqData = '0;
        EngBusy = 1'b0; EngDone = 1'b0; EngNack = 1'b0; EngRdData = '0;
        tick(3);
        chk("rst_grant",    16'(Grant),    16'h0);
        chk("rst_done",     16'(Done),     16'h0);
        chk("rst_enggo",    16'(EngGo),    16'h0);
        chk("rst_rddata",   16'(RdData),   16'h0);
        chk("rst_ackerr",   16'(AckErr),   16'h0);
        chk("rst_timedout", 16'(TimedOut), 16'h0);
        chk("rst_engaddr",  16'(EngAddr),  16'h0);
        chk("rst_engdata",  16'(EngData),  16'h0);
        Reset = 1'b1;
        tick(2);

        // EngBusy blocks arbitration, then single write to 0x48
        EngBusy = 1'b1;
        Req = 2'b01; ReqAddr = {7'h50, 7'h48}; ReqRW = 2'b10; ReqData = {8'h00, 8'hA5};
        tick(4);
        chk("busy_block_grant", 16'(Grant), 16'h0);
        EngBusy = 1'b0;
        wait_go(1'b0, 10, g, stale);
        chk("wr_grant",   16'(Grant),   16'h1);
        chk("wr_engaddr", 16'(EngAddr), 16'h48);
        chk("wr_engdata", 16'(EngData), 16'hA5);
        chk("wr_engrw",   16'(EngRW),   16'h0);
        tick(1);
        chk("wr_go_onecycle", 16'(EngGo), 16'h0);
        finish_txn(1'b0, 8'hC3, 39, d);
        chk("wr_done",   16'(Done),   16'h1);
        chk("wr_ackerr", 16'(AckErr), 16'h0);
        chk("wr_rddata_unchanged", 16'(RdData), 16'h0);
        Req = 2'b00;
        tick(1);
        chk("wr_done_pulse", 16'(Done), 16'h0);
        EngDone = 1'b1;
        seen = 2'b00;
        tick(1);
        EngDone = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | Done;
            tick(1);
        end
        chk("stray_engdone_ignored", 16'(seen),  16'h0);
        chk("idle_grant",            16'(Grant), 16'h0);

        // Simultaneous requests from reset: 0 first, then 1 (read 0x50)
        Reset = 1'b0;
        tick(1);
        Reset = 1'b1;
        Req = 2'b11; ReqData = {8'h00, 8'h11};
        wait_go(1'b0, 10, g, stale);
        chk("sim_first_grant", 16'(Grant),   16'h1);
        chk("sim_first_addr",  16'(EngAddr), 16'h48);
        finish_txn(1'b0, 8'h00, 5, d0);
        chk("sim_done0", 16'(Done), 16'h1);
        Req = 2'b10;
        wait_go(1'b0, 20, g, stale);
        chk("sim_second_grant", 16'(Grant),   16'h2);
        chk("sim_second_addr",  16'(EngAddr), 16'h50);
        chk("sim_second_rw",    16'(EngRW),   16'h1);
        chk("sim_gap_ok", 16'((g - d0) >= GAP + 2), 16'h1);
        finish_txn(1'b0, 8'h3C, 6, d);
        chk("sim_done1",   16'(Done),   16'h2);
        chk("sim_rddata",  16'(RdData), 16'h3C);
        chk("sim_ackerr1", 16'(AckErr), 16'h0);

        // Fairness with both requests held
        Req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            expg = (k % 2 == 1) ? 2'b10 : 2'b01;
            wait_go(1'b0, 20, g, stale);
            chk($sformatf("fair_grant%0d", k), 16'(Grant), 16'(expg));
            finish_txn(1'b0, 8'h5A, 3, d);
            chk($sformatf("fair_done%0d", k), 16'(Done), 16'(expg));
        end
        chk("fair_rddata", 16'(RdData), 16'h5A);
        Req = 2'b00;

        // NACK on a write from requester 0
        tick(6);
        Req = 2'b01;
        wait_go(1'b0, 20, g, stale);
        finish_txn(1'b1, 8'hEE, 8, d);
        chk("nack_done",     16'(Done),     16'h1);
        chk("nack_ackerr",   16'(AckErr),   16'h1);
        chk("nack_timedout", 16'(TimedOut), 16'h0);
        chk("nack_rddata",   16'(RdData),   16'h5A);
        Req = 2'b00;

        // Reset mid-transaction (asynchronous)
        tick(6);
        Req = 2'b10;
        wait_go(1'b0, 20, g, stale);
        tick(3);
        chk("pre_rst_grant", 16'(Grant), 16'h2);
        #2 Reset = 1'b0;
        #1;
        chk("arst_grant",   16'(Grant),   16'h0);
        chk("arst_engaddr", 16'(EngAddr), 16'h0);
        chk("arst_engrw",   16'(EngRW),   16'h0);
        chk("arst_ackerr",  16'(AckErr),  16'h0);
        chk("arst_rddata",  16'(RdData),  16'h0);
        chk("arst_t_grant", 16'(t_Grant), 16'h0);
        @(negedge clock);
        Reset = 1'b1;
        EngRdData = 8'h77;
        wait_go(1'b0, 20, g, stale);
        chk("post_rst_no_stale_done", 16'(stale),   16'h0);
        chk("post_rst_grant",         16'(Grant),   16'h2);
        chk("post_rst_t_go",          16'(t_EngGo), 16'h1);

        // Timeout on the TimeoutCycles=20 instance; main instance keeps waiting
        d = -1;
        seen = 2'b00;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            seen = seen | Done;
            if (t_Done !== 2'b00) begin
                d = cyc;
                break;
            end
        end
        chk("to_latency",  16'(d - g),      16'd21);
        chk("to_done",     16'(t_Done),     16'h2);
        chk("to_ackerr",   16'(t_AckErr),   16'h1);
        chk("to_timedout", 16'(t_TimedOut), 16'h1);
        chk("to_rddata",   16'(t_RdData),   16'h0);
        chk("main_no_done_while_waiting", 16'(seen), 16'h0);
        wait_go(1'b1, 20, g2, stale);
        chk("to_idle_regrant", 16'(t_Grant), 16'h2);
        chk("to_gap_ok", 16'((g2 - d) >= GAP + 2), 16'h1);

        // Main instance completes its post-reset read
        finish_txn(1'b0, 8'h99, 2, d);
        chk("post_rst_done",   16'(Done),   16'h2);
        chk("post_rst_rddata", 16'(RdData), 16'h99);
        chk("post_rst_ackerr", 16'(AckErr), 16'h0);
        Req = 2'b00;
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_request_arbiter.md
# i2c_request_arbiter

Shares the single I2C master bit engine (the Go/SCL/SDA control-unit datapath) between two requesters. Each requester presents a one-byte read or write to a 7-bit slave address. The arbiter grants requesters round-robin and launches the engine with a one-cycle Go pulse. It then waits for completion or timeout, returns status and read data to the granted requester, and enforces a bus-free gap before the next transaction.

## Interface
Parameters:
- TimeoutCycles, 4096: clocks allowed from EngGo to EngDone before abort; counter width is $clog2(TimeoutCycles+1).
- GapCycles, 3: idle clocks between EngDone/abort and the next arbitration; must be ≥1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low reset; one clock, no other clock domains.
- Req  in  2  request per requester; held high until its Done pulse.
- ReqAddr  in  14  {addr1[6:0], addr0[6:0]}.
- ReqRW  in  2  1=read, 0=write, per requester.
- ReqData  in  16  {data1, data0} write bytes.
- Grant  out  2  one-hot owner of the engine; 0 when idle.
- Done  out  2  one-cycle completion pulse to the owner.
- AckErr  out  1  valid with Done: NACK or timeout.
- TimedOut  out  1  valid with Done: abort by timeout.
- RdData  out  8  valid with Done on reads; held until next Done.
- EngGo  out  1  one-cycle launch pulse to the bit engine.
- EngAddr/EngRW/EngData  out  7/1/8  command, stable from EngGo until Done.
- EngBusy  in  1  engine active.
- EngDone  in  1  one-cycle end-of-transaction pulse.
- EngNack  in  1  valid with EngDone.
- EngRdData  in  8  valid with EngDone.

## Operation
- States: IDLE, LAUNCH, WAIT_DONE, REPORT, GAP.
- IDLE: if any Req is high and EngBusy=0, pick a winner. If both requesters are high, pick the one not served last. The pointer resets to favour requester 0. Register Grant and the command fields, then go to LAUNCH.
- LAUNCH: EngGo=1 for exactly one cycle, clear the timeout counter, go to WAIT_DONE.
- WAIT_DONE: the counter increments each cycle.
  - EngDone → latch EngNack and EngRdData (the latter on reads), go to REPORT.
  - Counter reaching TimeoutCycles → AckErr=1, TimedOut=1, go to REPORT.
- REPORT: Done[owner]=1 for one cycle, update the round-robin pointer, Grant←0, load the gap counter, go to GAP.
- GAP: count GapCycles, then IDLE.
- Req dropped by the owner mid-transaction is ignored: the transaction completes and Done still pulses.
- Req from the non-owner is only sampled in IDLE.
- EngDone outside WAIT_DONE is ignored.
- RdData is unchanged on writes and on timeouts.
- Reset asserted at any time forces all outputs to 0 and the state to IDLE, and restores the pointer to favour requester 0.

## Timing
- Reset values: Grant=0, Done=0, AckErr=0, TimedOut=0, RdData=0, EngGo=0, EngAddr=0, EngRW=0, EngData=0.
- Req high in IDLE at edge N: Grant at N+1, EngGo at N+2.
- EngDone at edge M: Done, AckErr and RdData at M+1; Grant clears at M+2.
- Next EngGo is no earlier than M+3+GapCycles.
- Timeout: Done TimeoutCycles+1 cycles after EngGo.
- EngBusy high in IDLE blocks arbitration.

## Structure
- Shared package i2c_pkg holds:
  - the state encoding (IDLE, LAUNCH, WAIT_DONE, REPORT, GAP);
  - the 7-bit address and 8-bit data widths;
  - the RW encoding constants.
- One sub-module is natural: rr_arbiter2 (2-way round-robin pick with last-served pointer, combinational grant plus pointer register).
- The FSM and counters stay in the top module.

## Test plan
- Single write: Req=01, addr0=0x48, RW0=0, data0=0xA5; engine model returns EngDone, EngNack=0 after 40 cycles. Expected:
  - one EngGo with EngAddr=0x48, EngData=0xA5;
  - Done=01, AckErr=0.
- Simultaneous requests: Req=11 from reset. Expected:
  - requester 0 served first, then requester 1 (addr1=0x50, read, EngRdData=0x3C);
  - Done=10 with RdData=0x3C;
  - gap between EngDone and the second EngGo ≥ GapCycles+2.
- Fairness: Req=11 held for 4 transactions → Grant sequence 01,10,01,10.
- NACK: EngNack=1 with EngDone → Done=01, AckErr=1, TimedOut=0, RdData unchanged.
- Timeout: TimeoutCycles=20, engine never pulses EngDone → Done exactly 21 cycles after EngGo, AckErr=1, TimedOut=1, then IDLE after the gap.
- Reset mid-transaction: Reset low during WAIT_DONE → all outputs 0 asynchronously. After release, Req=10 is served first with no stale Done.
